fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_seq_ctrl_pkg.sv | 17 +
 rtl/fft_seq_ctrl_if.sv | 29 ++
 rtl/fft_seq_ctrl_updn_cnt.sv | 36 +++
 rtl/fft_seq_ctrl.sv | 107 ++++++++++
 tb/tb_fft_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_seq_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and default sizing for the FFT sequencing controller.
//   fsm_state_e        - controller states
//   *_DEF localparams  - default frame length, pipeline depth and credit count
package fft_ctrl_pkg;

  localparam int BLK_PER_FRAME_DEF = 32;
  localparam int PIPE_DEPTH_DEF    = 16;
  localparam int CREDITS_DEF       = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// fft_seq_ctrl_if: handshake/status bundle between the FFT sequencer and its environment.
//   master : environment side (drives start, in_valid, cbfp_valid, out_taken)
//   slave  : controller side  (drives in_ready, module1_valid, blk_idx, busy, frame_done, err)
interface fft_seq_ctrl_if #(
  parameter int BLK_PER_FRAME = fft_ctrl_pkg::BLK_PER_FRAME_DEF
);
  localparam int IW = (BLK_PER_FRAME > 1) ? $clog2(BLK_PER_FRAME) : 1;

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          module1_valid;
  logic [IW-1:0] blk_idx;
  logic          cbfp_valid;
  logic          out_taken;
  logic          busy;
  logic          frame_done;
  logic          err;

  modport master (
    output start, in_valid, cbfp_valid, out_taken,
    input  in_ready, module1_valid, blk_idx, busy, frame_done, err
  );

  modport slave (
    input  start, in_valid, cbfp_valid, out_taken,
    output in_ready, module1_valid, blk_idx, busy, frame_done, err
  );
endinterface

// File: rtl/fft_seq_ctrl_updn_cnt.sv
// updn_cnt: bounded up/down counter.
//   clk, rst : clock, synchronous active-high reset (loads RST_VAL)
//   inc, dec : count events; both together leave the count unchanged
//   cnt      : current count (0..MAX)
//   err      : combinational, high when an event would cross 0 or MAX;
//              the count holds in that cycle
module updn_cnt #(
  parameter int WIDTH   = 4,
  parameter int MAX     = 15,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             err
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    err   = (inc && cnt_q == WIDTH'(MAX)) || (dec && cnt_q == '0);
    cnt_d = cnt_q;
    if (!err) begin
      if (inc && !dec)      cnt_d = cnt_q + WIDTH'(1);
      else if (dec && !inc) cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= WIDTH'(RST_VAL);
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: issues BLK_PER_FRAME input blocks per frame into the FFT pipeline,
// bounded by output-buffer credits and pipeline occupancy, then waits for all
// blocks to return before pulsing frame_done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fft_seq_ctrl_if.slave (start/in_valid/cbfp_valid/out_taken in,
//              in_ready/module1_valid/blk_idx/busy/frame_done/err out)
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int BLK_PER_FRAME = BLK_PER_FRAME_DEF,
  parameter int PIPE_DEPTH    = PIPE_DEPTH_DEF,
  parameter int CREDITS       = CREDITS_DEF
) (
  input logic           clk,
  input logic           rst,
  fft_seq_ctrl_if.slave bus
);
  localparam int IW = (BLK_PER_FRAME > 1) ? $clog2(BLK_PER_FRAME) : 1;
  localparam int CW = $clog2(BLK_PER_FRAME + 1);  // must hold BLK_PER_FRAME itself
  localparam int FW = $clog2(PIPE_DEPTH + 1);
  localparam int KW = $clog2(CREDITS + 1);

  fsm_state_e    state_q, state_d;
  logic [CW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CW-1:0] ret_cnt_q, ret_cnt_d;
  logic          m1_vld_q, m1_vld_d;
  logic [IW-1:0] blk_idx_q, blk_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [FW-1:0] inflight;
  logic [KW-1:0] credit;
  logic          infl_err, cred_err, accept;

  assign bus.in_ready = (state_q == S_RUN) && (credit != '0) && (inflight < FW'(PIPE_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  updn_cnt #(.WIDTH(FW), .MAX(PIPE_DEPTH), .RST_VAL(0)) u_inflight (
    .clk(clk), .rst(rst), .inc(accept), .dec(bus.cbfp_valid), .cnt(inflight), .err(infl_err)
  );

  // Credits survive across frames: only rst reloads them.
  updn_cnt #(.WIDTH(KW), .MAX(CREDITS), .RST_VAL(CREDITS)) u_credit (
    .clk(clk), .rst(rst), .inc(bus.out_taken), .dec(accept), .cnt(credit), .err(cred_err)
  );

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    m1_vld_d  = accept;
    blk_idx_d = accept ? iss_cnt_q[IW-1:0] : blk_idx_q;
    err_d     = err_q | infl_err | cred_err |
                (bus.cbfp_valid && (state_q == S_IDLE || state_q == S_DONE));

    // A spurious return (nothing in flight) is not counted toward the frame.
    if (bus.cbfp_valid && !infl_err && (state_q == S_RUN || state_q == S_DRAIN))
      ret_cnt_d = ret_cnt_q + CW'(1);

    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d   = S_RUN;
        iss_cnt_d = '0;
        ret_cnt_d = '0;
      end
      S_RUN: if (accept) begin
        iss_cnt_d = iss_cnt_q + CW'(1);
        if (iss_cnt_q == CW'(BLK_PER_FRAME - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (ret_cnt_q == CW'(BLK_PER_FRAME)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Decoded from next state so the registered flags line up with the state.
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
      m1_vld_q  <= 1'b0;
      blk_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      m1_vld_q  <= m1_vld_d;
      blk_idx_q <= blk_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.module1_valid = m1_vld_q;
  assign bus.blk_idx       = blk_idx_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: vector table, directed frame scenarios and randomized traffic
// against a transaction-level reference model. A second DUT with 32 credits
// shares the same stimulus so the pipeline-depth bound can be observed.
module tb_fft_seq_ctrl;
  import fft_ctrl_pkg::*;

  localparam int BLK  = 32;
  localparam int PIPE = 16;
  localparam int CRED = 4;
  localparam int IW   = $clog2(BLK);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_seq_ctrl_if #(.BLK_PER_FRAME(BLK)) bus ();
  fft_seq_ctrl_if #(.BLK_PER_FRAME(BLK)) bus32 ();

  fft_seq_ctrl #(.BLK_PER_FRAME(BLK), .PIPE_DEPTH(PIPE), .CREDITS(CRED)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fft_seq_ctrl #(.BLK_PER_FRAME(BLK), .PIPE_DEPTH(PIPE), .CREDITS(32)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  assign bus32.start      = bus.start;
  assign bus32.in_valid   = bus.in_valid;
  assign bus32.cbfp_valid = bus.cbfp_valid;
  assign bus32.out_taken  = bus.out_taken;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_e;
  mstate_e ms;
  int m_infl, m_cred, m_iss, m_ret, m_idx;
  bit m_err, m_m1v, m_busy, m_done;

  function automatic bit m_ready();
    return (ms == M_RUN) && (m_cred > 0) && (m_infl < PIPE);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_tick();
    bit acc, cb, tk, inf_bad, cred_bad;
    if (rst) begin
      ms = M_IDLE; m_infl = 0; m_cred = CRED; m_iss = 0; m_ret = 0; m_idx = 0;
      m_err = 0; m_m1v = 0; m_busy = 0; m_done = 0;
      return;
    end
    acc = bus.in_valid && m_ready();
    cb  = bus.cbfp_valid;
    tk  = bus.out_taken;
    // Any event pushing a counter past its range flags err and freezes that counter.
    inf_bad  = (acc && m_infl == PIPE) || (cb && m_infl == 0);
    cred_bad = (tk && m_cred == CRED) || (acc && m_cred == 0);
    if (inf_bad || cred_bad || (cb && (ms == M_IDLE || ms == M_DONE))) m_err = 1;
    if (!inf_bad)  m_infl += int'(acc) - int'(cb);
    if (!cred_bad) m_cred += int'(tk) - int'(acc);
    m_m1v = acc;
    if (acc) m_idx = m_iss;
    case (ms)
      M_IDLE: if (bus.start) begin ms = M_RUN; m_iss = 0; m_ret = 0; end
      M_RUN: begin
        if (cb && !inf_bad) m_ret++;
        if (acc) begin
          m_iss++;
          if (m_iss == BLK) ms = M_DRAIN;
        end
      end
      M_DRAIN: begin
        if (m_ret == BLK) ms = M_DONE;
        if (cb && !inf_bad) m_ret++;
      end
      default: ms = M_IDLE;
    endcase
    m_busy = (ms == M_RUN) || (ms == M_DRAIN);
    m_done = (ms == M_DONE);
  endfunction

  // ---------------- clocking / environment ----------------
  int cyc = 0;
  int n_m1, n_m1_32, n_done;
  bit idx_ok;
  int cb_due[$];
  int tk_due[$];

  task automatic step();
    logic [28:0] act, exp;
    model_tick();
    @(posedge clk);
    #1;
    act = {bus.in_ready, bus.module1_valid, bus.busy, bus.frame_done, bus.err,
           bus.module1_valid ? 8'(bus.blk_idx) : 8'd0, 8'(dut.inflight), 8'(dut.credit)};
    exp = {m_ready(), m_m1v, m_busy, m_done, m_err,
           m_m1v ? 8'(m_idx) : 8'd0, 8'(m_infl), 8'(m_cred)};
    chk("model", 64'(act), 64'(exp));
    cyc++;
  endtask

  task automatic clr_env();
    cb_due.delete(); tk_due.delete();
    n_m1 = 0; n_m1_32 = 0; n_done = 0; idx_ok = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 0; bus.in_valid = 0; bus.cbfp_valid = 0; bus.out_taken = 0;
    clr_env();
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Downstream emulation: a return 5 cycles after each issue, optionally a
  // freed slot 1 cycle after each return. Stops early once stop_idx is issued.
  task automatic env(input int n, input bit ret_en, input bit tak_en, input int stop_idx);
    for (int k = 0; k < n; k++) begin
      bus.cbfp_valid = 1'b0;
      bus.out_taken  = 1'b0;
      if (cb_due.size() > 0 && cb_due[0] <= cyc) begin
        void'(cb_due.pop_front());
        bus.cbfp_valid = 1'b1;
        if (tak_en) tk_due.push_back(cyc + 1);
      end
      if (tk_due.size() > 0 && tk_due[0] <= cyc) begin
        void'(tk_due.pop_front());
        bus.out_taken = 1'b1;
      end
      step();
      if (bus.module1_valid) begin
        if (bus.blk_idx != IW'(n_m1)) idx_ok = 0;
        n_m1++;
        if (ret_en) cb_due.push_back(cyc + 5);
      end
      if (bus32.module1_valid) n_m1_32++;
      if (bus.frame_done) n_done++;
      if (bus.module1_valid && int'(bus.blk_idx) == stop_idx) break;
    end
    bus.cbfp_valid = 1'b0;
    bus.out_taken  = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit st, iv, cb, tk;
    bit rdy, m1v, busy;
    int idx, infl, cred;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0,0,0,0, 0,0,0, 0,0,4};
    tbl[1]  = '{1,0,0,0, 1,0,1, 0,0,4};
    tbl[2]  = '{0,1,0,0, 1,1,1, 0,1,3};
    tbl[3]  = '{0,1,0,0, 1,1,1, 1,2,2};
    tbl[4]  = '{0,1,0,1, 1,1,1, 2,3,2};  // accept + out_taken: credit unchanged
    tbl[5]  = '{0,0,1,0, 1,0,1, 0,2,2};
    tbl[6]  = '{0,1,1,0, 1,1,1, 3,2,1};  // accept + cbfp_valid: inflight unchanged
    tbl[7]  = '{0,1,0,0, 0,1,1, 4,3,0};
    tbl[8]  = '{0,1,0,0, 0,0,1, 0,3,0};
    tbl[9]  = '{0,0,0,1, 1,0,1, 0,3,1};
    tbl[10] = '{1,0,0,0, 1,0,1, 0,3,1};  // start ignored while running
    tbl[11] = '{0,1,0,0, 0,1,1, 5,4,0};

    // reset state
    do_reset();
    chk("reset_state",
        64'({bus.in_ready, bus.module1_valid, bus.blk_idx, bus.busy, bus.frame_done, bus.err,
             8'(dut.credit), 8'(dut.inflight)}),
        64'({1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd0}));

    // table-driven vectors
    foreach (tbl[i]) begin
      bus.start = tbl[i].st; bus.in_valid = tbl[i].iv;
      bus.cbfp_valid = tbl[i].cb; bus.out_taken = tbl[i].tk;
      step();
      chk($sformatf("vec%0d", i),
          64'({bus.in_ready, bus.module1_valid, bus.busy, bus.err,
               bus.module1_valid ? 8'(bus.blk_idx) : 8'd0, 8'(dut.inflight), 8'(dut.credit)}),
          64'({tbl[i].rdy, tbl[i].m1v, tbl[i].busy, 1'b0,
               tbl[i].m1v ? 8'(tbl[i].idx) : 8'd0, 8'(tbl[i].infl), 8'(tbl[i].cred)}));
    end

    // full frame with returns and freed slots
    do_reset();
    bus.in_valid = 1'b1;
    do_start();
    env(150, 1, 1, -1);
    chk("frame_issues", 64'(n_m1), 64'd32);
    chk("frame_idx_seq", 64'(idx_ok), 64'd1);
    chk("frame_done_cnt", 64'(n_done), 64'd1);
    chk("frame_err", 64'(bus.err), 64'd0);
    chk("frame_idle", 64'({bus.busy, bus.in_ready}), 64'd0);

    // out_taken withheld: credits stall after 4, one freed slot admits one more
    do_reset();
    bus.in_valid = 1'b1;
    do_start();
    env(30, 1, 0, -1);
    chk("credit_stall_cnt", 64'(n_m1), 64'd4);
    chk("credit_stall_rdy", 64'(bus.in_ready), 64'd0);
    tk_due.push_back(cyc);
    env(20, 1, 0, -1);
    chk("one_credit_one_issue", 64'(n_m1), 64'd5);

    // no returns: 4 credits bind first; with 32 credits pipeline depth binds
    do_reset();
    bus.in_valid = 1'b1;
    do_start();
    env(40, 0, 0, -1);
    chk("no_ret_cred4", 64'(n_m1), 64'd4);
    chk("no_ret_cred32", 64'(n_m1_32), 64'd16);
    chk("no_ret_rdy", 64'({bus.in_ready, bus32.in_ready}), 64'd0);

    // cbfp_valid in IDLE -> sticky err through a frame, cleared by rst
    do_reset();
    bus.cbfp_valid = 1'b1;
    step();
    bus.cbfp_valid = 1'b0;
    chk("err_idle_ret", 64'(bus.err), 64'd1);
    bus.in_valid = 1'b1;
    do_start();
    env(150, 1, 1, -1);
    chk("err_frame_done", 64'(n_done), 64'd1);
    chk("err_sticky", 64'(bus.err), 64'd1);
    do_reset();
    chk("err_cleared", 64'(bus.err), 64'd0);

    // rst mid-frame at blk_idx 10, then restart from 0
    bus.in_valid = 1'b1;
    do_start();
    env(200, 1, 1, 10);
    chk("reached_idx10", 64'(n_m1), 64'd11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midframe_rst",
        64'({bus.busy, bus.in_ready, bus.module1_valid, 8'(dut.credit), 8'(dut.inflight)}),
        64'({1'b0, 1'b0, 1'b0, 8'd4, 8'd0}));
    clr_env();
    do_start();
    env(20, 1, 1, -1);
    chk("restart_idx0", 64'({idx_ok, n_m1 > 0}), 64'({1'b1, 1'b1}));

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst            = ($urandom_range(0, 299) == 0);
      bus.start      = ($urandom_range(0, 15) == 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.cbfp_valid = (m_infl > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 63) == 0);
      bus.out_taken  = (m_cred < CRED && $urandom_range(0, 2) == 0) || ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
